iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle 32-bit integer divide/remainder unit that sits beside the combinational ALU in the execute stage of the multi-cycle CPU.
- The ALU handles single-cycle add/sub/logic/compare. This block handles the operation the ALU cannot: it produces quotient or remainder, one bit per cycle.
- Operands enter through a valid/ready request handshake; the result leaves through a valid/ready response handshake. The controller can stall on either side.

Parameters:
- DATA_WIDTH, 32, operand and result width; the iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- A  input  DATA_WIDTH  dividend.
- B  input  DATA_WIDTH  divisor.
- DIVop  input  2  operation: 00 DIV signed quotient, 01 DIVU unsigned quotient, 10 REM signed remainder, 11 REMU unsigned remainder.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Result  output  DATA_WIDTH  quotient or remainder.
- DivByZero  output  1  set with out_valid when B was 0.

Behaviour:
- Clock and reset: one clock domain; rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, Result=0, DivByZero=0, all internal registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid & in_ready) latches A, B and DIVop.
  - If B==0, go to DONE. Otherwise load magnitudes and the bit counter (DATA_WIDTH) and go to CALC.
- Operand preparation:
  - Signed ops (DIVop[0]=0): use |A| and |B|. Record q_neg = A[31]^B[31] and r_neg = A[31].
  - Unsigned ops: q_neg = r_neg = 0.
- CALC:
  - in_ready=0.
  - Each cycle performs one restoring step on a 33-bit partial remainder:
    - shift {rem, dvd} left by 1 and form trial = rem - divisor;
    - if trial is non-negative, rem = trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - The counter decrements each cycle. After DATA_WIDTH steps, go to DONE.
- DONE entry:
  - Result = DIVop[1] ? (r_neg ? -rem : rem) : (q_neg ? -quot : quot).
  - out_valid=1.
- DONE hold and exit:
  - Result and DivByZero hold stable while out_valid=1 and out_ready=0.
  - When out_valid & out_ready, clear out_valid and return to IDLE (in_ready=1 next cycle).
  - No back-to-back overlap: a new request is accepted at the earliest one cycle after the response handshake.
- Latency, counting the request handshake edge as cycle 0:
  - normal operation: out_valid rises after edge 1+DATA_WIDTH, i.e. 33 cycles;
  - divide by zero: out_valid rises after edge 1.
- Divide by zero (B==0):
  - DivByZero=1, CALC is skipped.
  - Quotient ops return 0xFFFFFFFF.
  - Remainder ops return A unchanged (original sign).
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV): Result=0x80000000. REM of the same operands gives 0, with DivByZero=0. The magnitude path produces this naturally; no special case is required, but it must hold.
- Negation uses two's complement at DATA_WIDTH bits; magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- in_valid while busy (CALC/DONE) is ignored. Operand inputs are don't-care outside the handshake cycle.
- Asynchronous reset in any state returns immediately to the reset values; the in-flight operation is discarded.

Test Plan:
- DIVU A=100, B=7 -> out_valid exactly 33 cycles after handshake, Result=14, DivByZero=0. REMU on the same operands -> Result=2.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Result=0xFFFFFFFD (-3). REM -> Result=0xFFFFFFFF (-1). REM A=7, B=-2 -> Result=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> Result=0x80000000. REM on the same operands -> Result=0. DIVU A=0xFFFFFFFF, B=1 -> Result=0xFFFFFFFF.
- DIVU A=5, B=0 -> out_valid 1 cycle after handshake, Result=0xFFFFFFFF, DivByZero=1. REM A=-5, B=0 -> Result=0xFFFFFFFB.
- Hold out_ready=0 for 10 cycles after out_valid, toggling in_valid and A/B meanwhile -> Result stable, in_ready=0, no new request accepted. Then out_ready=1 -> in_ready=1 next cycle.
- Drive rst_n low asynchronously mid-CALC (cycle 15) -> out_valid=0, in_ready=1 immediately. After release, a new DIVU 9/3 -> Result=3 after 33 cycles.

Source files
------------

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// It produces one quotient bit per cycle and uses valid/ready on both sides.
module iter_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [1:0]            DIVop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  DivByZero
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  logic [DW-1:0]  rem;
  logic [DW-1:0]  dvd;
  logic [DW-1:0]  dvs;
  logic [CW-1:0]  cnt;
  logic [1:0]     op;
  logic           q_neg;
  logic           r_neg;
  logic           dbz;

  logic           sgn;
  logic           a_neg;
  logic           b_neg;
  logic           b_zero;
  logic           accept;
  logic [DW-1:0]  abs_a;
  logic [DW-1:0]  abs_b;
  logic [DW:0]    shifted;
  logic [DW:0]    trial;
  logic [DW-1:0]  quot_fin;
  logic [DW-1:0]  rem_fin;
  logic [DW-1:0]  res_fin;

  always_comb begin
    sgn      = ~DIVop[0];
    a_neg    = sgn & A[DW-1];
    b_neg    = sgn & B[DW-1];
    abs_a    = a_neg ? -A : A;
    abs_b    = b_neg ? -B : B;
    b_zero   = (B == '0);
    accept   = in_valid & in_ready;
    shifted  = {rem, dvd[DW-1]};
    trial    = shifted - {1'b0, dvs};
    quot_fin = q_neg ? -dvd : dvd;
    rem_fin  = r_neg ? -rem : rem;
    res_fin  = op[1] ? rem_fin : quot_fin;
  end

  // dvd doubles as the quotient register.
  // Divide by zero preloads it and rem with the final answers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      DivByZero <= 1'b0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      op        <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op       <= DIVop;
            dbz      <= b_zero;
            in_ready <= 1'b0;
            if (b_zero) begin
              rem   <= A;
              dvd   <= '1;
              dvs   <= '0;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              cnt   <= '0;
              state <= DONE;
            end else begin
              rem   <= '0;
              dvd   <= abs_a;
              dvs   <= abs_b;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= CW'(DW);
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          dvd <= {dvd[DW-2:0], ~trial[DW]};
          rem <= trial[DW] ? shifted[DW-1:0]
                           : trial[DW-1:0];
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            Result    <= res_fin;
            DivByZero <= dbz;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            DivByZero <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed test bench for iter_divider.
// It covers unsigned and signed ops, overflow, divide by zero, backpressure and async reset.
`timescale 1ns/1ps
module tb_iter_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  divop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;

  int vectors;
  int miscompares;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  iter_divider #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .DIVop     (divop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .DivByZero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for in_ready, then presents one request.
  // It returns #1 after the handshake edge.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                       input logic [1:0] vop);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    divop    = vop;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0BAD_F00D;
  endtask

  // Counts edges after the handshake edge until out_valid is seen.
  // It returns -1 if out_valid never appears.
  task automatic wait_out(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [1:0] vop, output int lat,
                        output logic [31:0] res, output logic dz);
    issue(va, vb, vop);
    wait_out(lat);
    res = result;
    dz  = div_by_zero;
    pop();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    divop     = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset in_ready got %b want 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset Result got %h want 0", result);
    end
    vectors++;
    if (div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset DivByZero got %b want 0", div_by_zero);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] va [5] = '{32'd100, 32'd100, 32'hFFFFFFFF,
                            32'h12345678, 32'hFFFFFFFF};
    logic [31:0] vb [5] = '{32'd7, 32'd7, 32'd1,
                            32'h100, 32'hFFFFFFFF};
    logic [1:0]  vo [5] = '{OP_DIVU, OP_REMU, OP_DIVU,
                            OP_REMU, OP_DIVU};
    logic [31:0] ve [5] = '{32'd14, 32'd2, 32'hFFFFFFFF,
                            32'h78, 32'd1};
    int          lat;
    logic [31:0] res;
    logic        dz;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vo[i], lat, res, dz);
      vectors++;
      if (res !== ve[i]) begin
        miscompares++;
        $display("FAIL unsigned[%0d] Result got %h want %h", i, res, ve[i]);
      end
      vectors++;
      if (lat !== 33) begin
        miscompares++;
        $display("FAIL unsigned[%0d] latency got %0d want 33", i, lat);
      end
      vectors++;
      if (dz !== 1'b0) begin
        miscompares++;
        $display("FAIL unsigned[%0d] DivByZero got %b want 0", i, dz);
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7,
                            32'hFFFFFF9C, 32'hFFFFFF9C};
    logic [31:0] vb [5] = '{32'd2, 32'd2, 32'hFFFFFFFE,
                            32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [1:0]  vo [5] = '{OP_DIV, OP_REM, OP_REM, OP_DIV, OP_REM};
    logic [31:0] ve [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1,
                            32'd14, 32'hFFFFFFFE};
    int          lat;
    logic [31:0] res;
    logic        dz;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vo[i], lat, res, dz);
      vectors++;
      if (res !== ve[i]) begin
        miscompares++;
        $display("FAIL signed[%0d] Result got %h want %h", i, res, ve[i]);
      end
      vectors++;
      if (lat !== 33) begin
        miscompares++;
        $display("FAIL signed[%0d] latency got %0d want 33", i, lat);
      end
    end
  endtask

  task automatic test_overflow();
    int          lat;
    logic [31:0] res;
    logic        dz;
    run_op(32'h80000000, 32'hFFFFFFFF, OP_DIV, lat, res, dz);
    vectors++;
    if (res !== 32'h80000000) begin
      miscompares++;
      $display("FAIL ovf_div Result got %h want 80000000", res);
    end
    vectors++;
    if (dz !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_div DivByZero got %b want 0", dz);
    end
    run_op(32'h80000000, 32'hFFFFFFFF, OP_REM, lat, res, dz);
    vectors++;
    if (res !== 32'h0) begin
      miscompares++;
      $display("FAIL ovf_rem Result got %h want 0", res);
    end
    vectors++;
    if (dz !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_rem DivByZero got %b want 0", dz);
    end
  endtask

  task automatic test_div_by_zero();
    logic [31:0] va [4] = '{32'd5, 32'hFFFFFFFB, 32'd5, 32'hFFFFFFFB};
    logic [1:0]  vo [4] = '{OP_DIVU, OP_REM, OP_REMU, OP_DIV};
    logic [31:0] ve [4] = '{32'hFFFFFFFF, 32'hFFFFFFFB, 32'd5,
                            32'hFFFFFFFF};
    int          lat;
    logic [31:0] res;
    logic        dz;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], 32'h0, vo[i], lat, res, dz);
      vectors++;
      if (res !== ve[i]) begin
        miscompares++;
        $display("FAIL dbz[%0d] Result got %h want %h", i, res, ve[i]);
      end
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("FAIL dbz[%0d] latency got %0d want 1", i, lat);
      end
      vectors++;
      if (dz !== 1'b1) begin
        miscompares++;
        $display("FAIL dbz[%0d] DivByZero got %b want 1", i, dz);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(32'd100, 32'd7, OP_DIVU);
    wait_out(lat);
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL bp latency got %0d want 33", lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 32'h1000 + i;
      b        = (i % 3 == 0) ? 32'h0 : 32'd3;
      divop    = i[1:0];
      @(posedge clk);
      #1;
      if (result !== 32'd14 || in_ready !== 1'b0 ||
          out_valid !== 1'b1 || div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] Result=%h in_ready=%b out_valid=%b want 0000000e/0/1",
                 i, result, in_ready, out_valid);
      end
    end
    vectors++;
    if (bad != 0) miscompares++;
    in_valid = 1'b0;
    pop();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release in_ready got %b want 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release out_valid got %b want 0", out_valid);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_no_accept stray activity in %0d cycles want 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int          lat;
    logic [31:0] res;
    logic        dz;
    issue(32'd100, 32'd7, OP_DIVU);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arst out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL arst in_ready got %b want 1", in_ready);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd9, 32'd3, OP_DIVU, lat, res, dz);
    vectors++;
    if (res !== 32'd3) begin
      miscompares++;
      $display("FAIL arst_next Result got %h want 3", res);
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL arst_next latency got %0d want 33", lat);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_by_zero();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
